// File: rtl/debounce_bank.sv
// N-channel debouncer: 2-flop synchroniser, stability counter, rise/fall/press
// pulses and an optional per-channel auto-repeat FSM driving press.
//
// Auto-repeat FSM (per channel, present only when REPEAT_EN != 0)
//   state   | meaning
//   ST_IDLE | level is 0, no repeat timing running
//   ST_HOLD | level is 1, timing the initial hold before the first repeat
//   ST_RPT  | level is 1, emitting a repeat pulse every REPEAT_CYCLES
module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 4095,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press
);

  localparam int            CW          = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RPT} rpt_state_t;

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          cand;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic          press_q;
    logic          accept;
    logic          rise_nxt;
    logic          fall_nxt;
    logic          rep_pulse;

    // The counter saturates once the candidate is accepted, so accept stays
    // high while the input is steady; edges are qualified against level.
    assign accept   = (sync2[i] == cand) && (cnt == STABLE_LAST);
    assign rise_nxt = accept & cand & ~level_q;
    assign fall_nxt = accept & ~cand & level_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand    <= 1'b0;
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        press_q <= 1'b0;
      end else begin
        rise_q  <= rise_nxt;
        fall_q  <= fall_nxt;
        press_q <= rise_nxt | rep_pulse;
        if (sync2[i] != cand) begin
          cand <= sync2[i];
          cnt  <= '0;
        end else if (cnt == STABLE_LAST) begin
          level_q <= cand;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    if (REPEAT_EN != 0) begin : g_rpt
      localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int RW   = $clog2(RMAX);
      localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
      localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);

      rpt_state_t    state_q;
      rpt_state_t    state_d;
      logic [RW-1:0] rcnt_q;
      logic [RW-1:0] rcnt_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      // Release is checked first so it suppresses a coincident repeat pulse.
      always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rep_pulse = 1'b0;
        if (fall_nxt) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (rise_nxt) begin
                state_d = ST_HOLD;
                rcnt_d  = '0;
              end
            end
            ST_HOLD: begin
              if (rcnt_q == HOLD_LAST) begin
                rep_pulse = 1'b1;
                rcnt_d    = '0;
                state_d   = ST_RPT;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            ST_RPT: begin
              if (rcnt_q == RPT_LAST) begin
                rep_pulse = 1'b1;
                rcnt_d    = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end
    end else begin : g_norpt
      assign rep_pulse = 1'b0;
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign press[i] = press_q;
  end

endmodule
